// File: rtl/ltc2600_update_scheduler.sv
// LTC2600 update scheduler: keeps per-channel shadow codes and dirty bits,
// picks pending work round-robin and hands one command frame at a time to
// the serial write core, waiting for its completion edge (or a timeout).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | nothing in flight; choose pd > dirty channel > update-all
// ISSUE  | one cycle: latch frame fields, pulse send_new_cmd
// WAIT   | frame held stable until completion edge or timeout
module ltc2600_update_scheduler #(
   parameter int DATA_WIDTH     = 16,
   parameter int N_CH           = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  ch_wr_en,
   input  logic [2:0]            ch_wr_addr,
   input  logic [DATA_WIDTH-1:0] ch_wr_data,
   input  logic                  batch_mode,
   input  logic                  pd_req,
   input  logic                  clear_err,
   output logic                  send_new_cmd,
   output logic [3:0]            command,
   output logic [3:0]            address,
   output logic [DATA_WIDTH-1:0] data,
   input  logic                  write_complete,
   output logic                  busy,
   output logic [N_CH-1:0]       dirty,
   output logic                  timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [3:0] CMD_WR_UPD  = 4'b0011;
   localparam logic [3:0] CMD_WR_IN   = 4'b0000;
   localparam logic [3:0] CMD_UPD_ALL = 4'b0001;
   localparam logic [3:0] CMD_PD_ALL  = 4'b0100;
   localparam logic [3:0] ADDR_ALL    = 4'b1111;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   typedef enum logic [1:0] {K_CH, K_PD, K_UPD} kind_t;

   state_t                state_q, state_d;
   kind_t                 kind_q, kind_d;
   logic [2:0]            sel_q, sel_d;
   logic [2:0]            ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] shadow_q [N_CH];
   logic [DATA_WIDTH-1:0] shadow_d [N_CH];
   logic [N_CH-1:0]       dirty_q, dirty_d;
   logic                  batch_pending_q, batch_pending_d;
   logic                  pd_pending_q, pd_pending_d;
   logic                  send_q, send_d;
   logic [3:0]            cmd_q, cmd_d;
   logic [3:0]            addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  wc_q, wc_d;
   logic                  wc_prev_q, wc_prev_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic                  wc_rise;
   logic                  wr_hit;
   logic                  rr_found;
   logic [2:0]            rr_sel;
   logic [2:0]            rr_idx;

   assign wc_rise = wc_q & ~wc_prev_q;
   assign wr_hit  = ch_wr_en && (int'(ch_wr_addr) < N_CH);
   assign wc_d      = write_complete;
   assign wc_prev_d = wc_q;

   // Round-robin search: first dirty channel at or above the pointer, wrapping.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = '0;
      rr_idx   = '0;
      for (int i = 0; i < N_CH; i++) begin
         rr_idx = 3'((int'(ptr_q) + i) % N_CH);
         if (!rr_found && dirty_q[rr_idx]) begin
            rr_found = 1'b1;
            rr_sel   = rr_idx;
         end
      end
   end

   // Next-state, frame fields and bookkeeping; host writes applied last so a
   // write landing on the channel being issued keeps its dirty bit set.
   always_comb begin
      state_d         = state_q;
      kind_d          = kind_q;
      sel_d           = sel_q;
      ptr_d           = ptr_q;
      shadow_d        = shadow_q;
      dirty_d         = dirty_q;
      batch_pending_d = batch_pending_q;
      pd_pending_d    = pd_pending_q | pd_req;
      send_d          = 1'b0;
      cmd_d           = cmd_q;
      addr_d          = addr_q;
      data_d          = data_q;
      cnt_d           = cnt_q;
      err_d           = err_q & ~clear_err;

      case (state_q)
         S_IDLE: begin
            if (pd_pending_q) begin
               kind_d  = K_PD;
               state_d = S_ISSUE;
            end else if (rr_found) begin
               kind_d  = K_CH;
               sel_d   = rr_sel;
               state_d = S_ISSUE;
            end else if (batch_pending_q) begin
               kind_d  = K_UPD;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            send_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
            case (kind_q)
               K_CH: begin
                  cmd_d          = batch_mode ? CMD_WR_IN : CMD_WR_UPD;
                  addr_d         = {1'b0, sel_q};
                  data_d         = shadow_q[sel_q];
                  dirty_d[sel_q] = 1'b0;
                  ptr_d          = (int'(sel_q) == N_CH - 1) ? 3'd0 : sel_q + 3'd1;
                  if (batch_mode) begin
                     batch_pending_d = 1'b1;
                  end
               end
               K_PD: begin
                  cmd_d  = CMD_PD_ALL;
                  addr_d = ADDR_ALL;
                  data_d = '0;
               end
               default: begin
                  cmd_d  = CMD_UPD_ALL;
                  addr_d = ADDR_ALL;
                  data_d = '0;
               end
            endcase
         end
         S_WAIT: begin
            if (wc_rise) begin
               if (kind_q == K_PD) begin
                  pd_pending_d = pd_req;
               end else if (kind_q == K_UPD) begin
                  batch_pending_d = 1'b0;
               end
               state_d = S_IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               cnt_d = cnt_q + CNT_W'(1);
               err_d = 1'b1;
               if (kind_q == K_CH) begin
                  dirty_d[sel_q] = 1'b1;
               end
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (wr_hit) begin
         shadow_d[ch_wr_addr] = ch_wr_data;
         dirty_d[ch_wr_addr]  = 1'b1;
      end
   end

   // All scheduler state; reset drops any frame in flight without retry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q         <= S_IDLE;
         kind_q          <= K_CH;
         sel_q           <= '0;
         ptr_q           <= '0;
         for (int i = 0; i < N_CH; i++) begin
            shadow_q[i] <= '0;
         end
         dirty_q         <= '0;
         batch_pending_q <= 1'b0;
         pd_pending_q    <= 1'b0;
         send_q          <= 1'b0;
         cmd_q           <= '0;
         addr_q          <= '0;
         data_q          <= '0;
         wc_q            <= 1'b0;
         wc_prev_q       <= 1'b0;
         cnt_q           <= '0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         kind_q          <= kind_d;
         sel_q           <= sel_d;
         ptr_q           <= ptr_d;
         shadow_q        <= shadow_d;
         dirty_q         <= dirty_d;
         batch_pending_q <= batch_pending_d;
         pd_pending_q    <= pd_pending_d;
         send_q          <= send_d;
         cmd_q           <= cmd_d;
         addr_q          <= addr_d;
         data_q          <= data_d;
         wc_q            <= wc_d;
         wc_prev_q       <= wc_prev_d;
         cnt_q           <= cnt_d;
         err_q           <= err_d;
      end
   end

   assign send_new_cmd = send_q;
   assign command      = cmd_q;
   assign address      = addr_q;
   assign data         = data_q;
   assign busy         = (state_q != S_IDLE);
   assign dirty        = dirty_q;
   assign timeout_err  = err_q;

endmodule

// File: tb/tb_ltc2600_update_scheduler.sv
// Directed scenarios plus randomized host traffic for the LTC2600 scheduler.
// A small writer responder records every frame; a DAC-level model (input
// registers + DAC registers, LTC2600 command semantics) checks final codes.
module tb_ltc2600_update_scheduler;
   localparam int DW  = 16;
   localparam int NCH = 8;
   localparam int TO  = 48;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          ch_wr_en = 1'b0;
   logic [2:0]    ch_wr_addr = '0;
   logic [DW-1:0] ch_wr_data = '0;
   logic          batch_mode = 1'b0;
   logic          pd_req = 1'b0;
   logic          clear_err = 1'b0;
   logic          write_complete = 1'b0;
   logic          send_new_cmd;
   logic [3:0]    command;
   logic [3:0]    address;
   logic [DW-1:0] data;
   logic          busy;
   logic [NCH-1:0] dirty;
   logic          timeout_err;

   int checks = 0;
   int failures = 0;

   always #10 clk = ~clk;

   ltc2600_update_scheduler #(
      .DATA_WIDTH(DW), .N_CH(NCH), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rstn(rstn), .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr),
      .ch_wr_data(ch_wr_data), .batch_mode(batch_mode), .pd_req(pd_req),
      .clear_err(clear_err), .send_new_cmd(send_new_cmd), .command(command),
      .address(address), .data(data), .write_complete(write_complete),
      .busy(busy), .dirty(dirty), .timeout_err(timeout_err)
   );

   // Writer responder: records frames, acks after a delay with a 2-cycle pulse.
   logic [23:0] frames[$];
   int ack_delay = 40;
   bit ack_en = 1'b1;
   bit rnd_ack = 1'b0;
   int ack_cnt = -1;
   int hold_cnt = 0;
   always @(negedge clk) begin
      if (!rstn) begin
         ack_cnt = -1;
         hold_cnt = 0;
         write_complete = 1'b0;
      end else begin
         if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) write_complete = 1'b0;
         end
         if (send_new_cmd) begin
            frames.push_back({command, address, data});
            ack_cnt = rnd_ack ? int'($urandom_range(12, 1)) : ack_delay;
         end else if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0 && ack_en) begin
               write_complete = 1'b1;
               hold_cnt = 2;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   int fbase = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fr(input int i);
      if (fbase + i < frames.size()) return {8'h00, frames[fbase + i]};
      return 32'hFFFF_FFFF;
   endfunction

   task automatic wr_start(input logic [2:0] ch, input logic [DW-1:0] v);
      @(negedge clk);
      ch_wr_en = 1'b1;
      ch_wr_addr = ch;
      ch_wr_data = v;
   endtask

   task automatic wr_end();
      @(negedge clk);
      ch_wr_en = 1'b0;
   endtask

   task automatic wait_send(input int budget, input string tag);
      int n = 0;
      bit got = 1'b0;
      while (!got && n < budget) begin
         @(negedge clk);
         n++;
         if (send_new_cmd) got = 1'b1;
      end
      chk({tag, "_send_seen"}, 32'(got), 32'd1);
   endtask

   task automatic wait_quiet(input int budget, input string tag);
      int q = 0;
      int n = 0;
      while (q < 4 && n < budget) begin
         @(negedge clk);
         n++;
         if (!busy && dirty == '0) q++;
         else q = 0;
      end
      chk({tag, "_quiet"}, 32'(q >= 4), 32'd1);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      ack_en = 1'b1;
      rnd_ack = 1'b0;
      batch_mode = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      fbase = frames.size();
   endtask

   logic [DW-1:0] last_val [NCH];
   bit            written  [NCH];
   logic [DW-1:0] inp_reg  [NCH];
   logic [DW-1:0] dac_reg  [NCH];

   initial begin
      int n;
      int bad;
      logic [2:0] ch;
      logic [DW-1:0] v;
      logic [23:0] f;

      // ---- reset state
      do_reset();
      chk("rst_send", 32'(send_new_cmd), 32'd0);
      chk("rst_command", 32'(command), 32'd0);
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dirty", 32'(dirty), 32'd0);
      chk("rst_err", 32'(timeout_err), 32'd0);

      // ---- 1: single immediate write, latency and frame fields
      ack_delay = 40;
      wr_start(3'd3, 16'h1234);
      wr_end();
      chk("t1_dirty_set", 32'(dirty), 32'h08);
      @(negedge clk);
      chk("t1_send_n1", 32'(send_new_cmd), 32'd0);
      @(negedge clk);
      chk("t1_send_n2", 32'(send_new_cmd), 32'd1);
      chk("t1_cmd", 32'(command), 32'h3);
      chk("t1_addr", 32'(address), 32'h3);
      chk("t1_data", 32'(data), 32'h1234);
      chk("t1_dirty_clr", 32'(dirty), 32'h00);
      chk("t1_busy", 32'(busy), 32'd1);
      wait_quiet(200, "t1");
      chk("t1_busy_end", 32'(busy), 32'd0);
      chk("t1_nframes", 32'(frames.size() - fbase), 32'd1);

      // ---- 2: round-robin order from pointer 0, then wrap
      do_reset();
      ack_delay = 20;
      wr_start(3'd7, 16'h007A);
      wr_end();
      wait_send(20, "t2_a");
      wr_start(3'd7, 16'h007B);
      wr_start(3'd0, 16'h000C);
      wr_start(3'd2, 16'h002C);
      wr_end();
      wait_send(100, "t2_b");
      wr_start(3'd0, 16'h000D);
      wr_end();
      wait_quiet(500, "t2");
      chk("t2_f0", fr(0), 32'h0037_007A);
      chk("t2_f1", fr(1), 32'h0030_000C);
      chk("t2_f2", fr(2), 32'h0032_002C);
      chk("t2_f3", fr(3), 32'h0037_007B);
      chk("t2_f4", fr(4), 32'h0030_000D);
      chk("t2_nframes", 32'(frames.size() - fbase), 32'd5);

      // ---- 3: batch load then a single update-all
      do_reset();
      ack_delay = 10;
      batch_mode = 1'b1;
      wr_start(3'd1, 16'hAAAA);
      wr_start(3'd5, 16'h5555);
      wr_end();
      wait_quiet(500, "t3");
      chk("t3_f0", fr(0), 32'h0001_AAAA);
      chk("t3_f1", fr(1), 32'h0005_5555);
      chk("t3_f2_cmdaddr", fr(2) >> 16, 32'h001F);
      chk("t3_nframes", 32'(frames.size() - fbase), 32'd3);
      batch_mode = 1'b0;

      // ---- 4: write to the in-flight channel forces a resend
      do_reset();
      ack_delay = 20;
      wr_start(3'd4, 16'h1111);
      wr_end();
      wait_send(20, "t4_a");
      wr_start(3'd4, 16'hBEEF);
      wr_end();
      chk("t4_dirty_inflight", 32'(dirty[4]), 32'd1);
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t4_idle_reached", 32'(busy), 32'd0);
      chk("t4_dirty_between", 32'(dirty[4]), 32'd1);
      wait_quiet(300, "t4");
      chk("t4_f0", fr(0), 32'h0034_1111);
      chk("t4_f1", fr(1), 32'h0034_BEEF);
      chk("t4_nframes", 32'(frames.size() - fbase), 32'd2);

      // ---- 5: timeout, retry, sticky flag and clear
      do_reset();
      ack_en = 1'b0;
      ack_delay = 5;
      wr_start(3'd6, 16'h0606);
      wr_end();
      wait_send(20, "t5_a");
      n = 0;
      while (!timeout_err && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t5_timeout_cycle", 32'(n), 32'(TO));
      chk("t5_dirty_reset", 32'(dirty[6]), 32'd1);
      chk("t5_busy_idle", 32'(busy), 32'd0);
      ack_en = 1'b1;
      wait_send(20, "t5_retry");
      chk("t5_retry_data", 32'(data), 32'h0606);
      wait_quiet(300, "t5");
      chk("t5_err_sticky", 32'(timeout_err), 32'd1);
      @(negedge clk);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      chk("t5_err_cleared", 32'(timeout_err), 32'd0);
      chk("t5_nframes", 32'(frames.size() - fbase), 32'd2);

      // ---- 6: power-down preempts pending channels, not the in-flight one
      do_reset();
      ack_delay = 20;
      wr_start(3'd1, 16'h0101);
      wr_end();
      wait_send(20, "t6_a");
      wr_start(3'd6, 16'h0606);
      wr_end();
      pd_req = 1'b1;
      @(negedge clk);
      pd_req = 1'b0;
      wait_quiet(500, "t6");
      chk("t6_f0", fr(0), 32'h0031_0101);
      chk("t6_f1_cmdaddr", fr(1) >> 16, 32'h004F);
      chk("t6_f2", fr(2), 32'h0036_0606);
      chk("t6_nframes", 32'(frames.size() - fbase), 32'd3);

      // reset mid-WAIT: outputs drop asynchronously, no resend afterwards
      wr_start(3'd2, 16'h2222);
      wr_end();
      wait_send(20, "t6_r");
      repeat (3) @(negedge clk);
      #3 rstn = 1'b0;
      #1;
      chk("t6r_send", 32'(send_new_cmd), 32'd0);
      chk("t6r_cmd", 32'(command), 32'd0);
      chk("t6r_addr", 32'(address), 32'd0);
      chk("t6r_data", 32'(data), 32'd0);
      chk("t6r_busy", 32'(busy), 32'd0);
      chk("t6r_dirty", 32'(dirty), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      fbase = frames.size();
      repeat (100) @(negedge clk);
      chk("t6r_no_resend", 32'(frames.size() - fbase), 32'd0);
      chk("t6r_busy_after", 32'(busy), 32'd0);

      // ---- 7: random immediate-mode traffic against a DAC model
      do_reset();
      rnd_ack = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         written[i] = 1'b0;
         last_val[i] = '0;
         inp_reg[i] = '0;
         dac_reg[i] = '0;
      end
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(2, 0) != 0) begin
            ch = 3'($urandom_range(NCH - 1, 0));
            v = DW'($urandom);
            wr_start(ch, v);
            last_val[ch] = v;
            written[ch] = 1'b1;
         end else begin
            wr_end();
         end
      end
      wr_end();
      wait_quiet(5000, "r1");
      bad = 0;
      for (int i = fbase; i < frames.size(); i++) begin
         f = frames[i];
         if (f[23:20] == 4'h3 && f[19:16] < 4'(NCH)) begin
            inp_reg[f[18:16]] = f[15:0];
            dac_reg[f[18:16]] = f[15:0];
         end else begin
            bad++;
         end
      end
      chk("r1_bad_frames", 32'(bad), 32'd0);
      for (int i = 0; i < NCH; i++) begin
         if (written[i]) chk($sformatf("r1_dac%0d", i), 32'(dac_reg[i]), 32'(last_val[i]));
      end

      // ---- 8: random batch traffic; DAC registers only move on update-all
      fbase = frames.size();
      batch_mode = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(1, 0) != 0) begin
            ch = 3'($urandom_range(NCH - 1, 0));
            v = DW'($urandom);
            wr_start(ch, v);
            last_val[ch] = v;
            written[ch] = 1'b1;
         end else begin
            wr_end();
         end
      end
      wr_end();
      wait_quiet(5000, "r2");
      bad = 0;
      for (int i = fbase; i < frames.size(); i++) begin
         f = frames[i];
         if (f[23:20] == 4'h0 && f[19:16] < 4'(NCH)) begin
            inp_reg[f[18:16]] = f[15:0];
         end else if (f[23:16] == 8'h1F) begin
            for (int c = 0; c < NCH; c++) dac_reg[c] = inp_reg[c];
         end else begin
            bad++;
         end
      end
      chk("r2_bad_frames", 32'(bad), 32'd0);
      chk("r2_last_is_update_all", fr(frames.size() - fbase - 1) >> 16, 32'h001F);
      for (int i = 0; i < NCH; i++) begin
         if (written[i]) chk($sformatf("r2_dac%0d", i), 32'(dac_reg[i]), 32'(last_val[i]));
      end
      batch_mode = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
